// File: rtl/mini_cpu_mc.sv
// mini_cpu_mc: multi-cycle mini processor with IDLE/FETCH/EXEC control,
// req/ack instruction fetch, logic ops, Z/C flags, branches, HALT/start
// control, a retire strobe and a combinational debug register read port.
module mini_cpu_mc #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NREGS  = 4,
  parameter int unsigned PC_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_data,
  output logic              halted,
  output logic              retire,
  output logic              flag_z,
  output logic              flag_c,
  input  logic [2:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int unsigned RIDX_W = $clog2(NREGS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC
  } state_e;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_LDI  = 4'd5,
    OP_BRZ  = 4'd6,
    OP_JMP  = 4'd7,
    OP_HALT = 4'd8
  } op_e;

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [15:0]         ir_q, ir_d;
  logic                z_q, z_d;
  logic                c_q, c_d;
  logic [DATA_W-1:0]   regs_q [NREGS];

  op_e                 opcode;
  logic [RIDX_W-1:0]   rd_idx, rs1_idx, rs2_idx, dbg_idx;
  logic [DATA_W-1:0]   op_a, op_b;
  logic [31:0]         imm32;
  logic [DATA_W-1:0]   imm_data;
  logic [PC_W-1:0]     imm_pc;
  logic [DATA_W:0]     sum_w, diff_w;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_c, alu_wr;
  logic                rf_we;
  logic [DATA_W-1:0]   rf_wdata;
  logic                unused_bits;

  // Instruction field decode; register indices keep only their low bits.
  assign opcode  = op_e'(ir_q[15:12]);
  assign rd_idx  = ir_q[9 +: RIDX_W];
  assign rs1_idx = ir_q[6 +: RIDX_W];
  assign rs2_idx = ir_q[3 +: RIDX_W];
  assign dbg_idx = dbg_sel[RIDX_W-1:0];

  // imm8 is zero-extended through 32 bits, then cut to the target width,
  // which covers both the widening and the truncating parameterisations.
  assign imm32    = {24'd0, ir_q[7:0]};
  assign imm_data = imm32[DATA_W-1:0];
  assign imm_pc   = imm32[PC_W-1:0];

  assign op_a = (rs1_idx == '0) ? '0 : regs_q[rs1_idx];
  assign op_b = (rs2_idx == '0) ? '0 : regs_q[rs2_idx];

  // Top bit of the widened sum is the carry; of the widened difference, the borrow.
  assign sum_w  = {1'b0, op_a} + {1'b0, op_b};
  assign diff_w = {1'b0, op_a} - {1'b0, op_b};

  assign dbg_data  = (dbg_idx == '0) ? '0 : regs_q[dbg_idx];
  assign imem_addr = pc_q;
  assign flag_z    = z_q;
  assign flag_c    = c_q;

  assign unused_bits = ^{dbg_sel, ir_q, imm32};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: start only matters in IDLE, ack only in FETCH.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start)    state_d = S_FETCH;
      S_FETCH: if (imem_ack) state_d = S_EXEC;
      S_EXEC:  state_d = (opcode == OP_HALT) ? S_IDLE : S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    imem_req = (state_q == S_FETCH);
    halted   = (state_q == S_IDLE);
    retire   = (state_q == S_EXEC);
  end

  // ALU result for the register-register opcodes.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_wr  = 1'b0;
    case (opcode)
      OP_ADD: begin alu_res = sum_w[DATA_W-1:0];  alu_c = sum_w[DATA_W];  alu_wr = 1'b1; end
      OP_SUB: begin alu_res = diff_w[DATA_W-1:0]; alu_c = diff_w[DATA_W]; alu_wr = 1'b1; end
      OP_AND: begin alu_res = op_a & op_b; alu_wr = 1'b1; end
      OP_OR:  begin alu_res = op_a | op_b; alu_wr = 1'b1; end
      OP_XOR: begin alu_res = op_a ^ op_b; alu_wr = 1'b1; end
      default: ;
    endcase
  end

  // Datapath next state: instruction latch in FETCH, pc/flags/writeback in EXEC.
  always_comb begin
    ir_d     = ir_q;
    pc_d     = pc_q;
    z_d      = z_q;
    c_d      = c_q;
    rf_we    = 1'b0;
    rf_wdata = alu_res;
    if (state_q == S_FETCH && imem_ack) ir_d = imem_data;
    if (state_q == S_EXEC) begin
      pc_d = pc_q + PC_W'(1);
      // Flags follow the computed result even when the write to R0 is dropped.
      if (alu_wr) begin
        rf_we = 1'b1;
        z_d   = (alu_res == '0);
        c_d   = alu_c;
      end
      case (opcode)
        OP_LDI: begin rf_we = 1'b1; rf_wdata = imm_data; end
        OP_BRZ: if (z_q) pc_d = imm_pc;
        OP_JMP: pc_d = imm_pc;
        default: ;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= '0;
      ir_q <= '0;
      z_q  <= 1'b0;
      c_q  <= 1'b0;
    end else begin
      pc_q <= pc_d;
      ir_q <= ir_d;
      z_q  <= z_d;
      c_q  <= c_d;
    end
  end

  // Register file; R0 is never written so it stays at its reset value of 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= '{default: '0};
    end else if (rf_we && rd_idx != '0) begin
      regs_q[rd_idx] <= rf_wdata;
    end
  end

endmodule

// File: tb/tb_mini_cpu_mc.sv
// Self-checking bench for mini_cpu_mc: directed scenarios plus randomized
// forward-branching programs, checked against an instruction-level model.
`timescale 1ns/1ps
module tb_mini_cpu_mc;
  localparam int DW = 8;
  localparam int NR = 4;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst, start, imem_req, imem_ack, halted, retire, flag_z, flag_c;
  logic [PW-1:0] imem_addr;
  logic [15:0]   imem_data;
  logic [2:0]    dbg_sel;
  logic [DW-1:0] dbg_data;

  logic          start4, req4, ack4, halted4, retire4, z4, c4;
  logic [3:0]    addr4;
  logic [15:0]   data4;
  logic [2:0]    sel4;
  logic [7:0]    dbg4;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] imem [256];
  int  mreg [NR];
  int  mpc;
  bit  mz, mc, mhalt;
  int  fetch_log [$];
  int  fixed_delay;
  bit  inject_start;

  always #10 clk = ~clk;

  mini_cpu_mc #(.DATA_W(DW), .NREGS(NR), .PC_W(PW)) dut (
    .clk(clk), .rst(rst), .start(start), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data), .halted(halted), .retire(retire),
    .flag_z(flag_z), .flag_c(flag_c), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  mini_cpu_mc #(.DATA_W(8), .NREGS(2), .PC_W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .imem_req(req4), .imem_addr(addr4),
    .imem_ack(ack4), .imem_data(data4), .halted(halted4), .retire(retire4),
    .flag_z(z4), .flag_c(c4), .dbg_sel(sel4), .dbg_data(dbg4)
  );

  function automatic logic [15:0] enc_r(int op, int rd, int rs1, int rs2);
    return {4'(op), 3'(rd), 3'(rs1), 3'(rs2), 3'b000};
  endfunction

  function automatic logic [15:0] enc_i(int op, int rd, int imm);
    return {4'(op), 3'(rd), 1'b0, 8'(imm)};
  endfunction

  function automatic int pick_delay();
    if (fixed_delay >= 0) return fixed_delay;
    return int'($urandom_range(0, 3));
  endfunction

  task automatic model_reset();
    foreach (mreg[i]) mreg[i] = 0;
    mpc = 0; mz = 0; mc = 0; mhalt = 1;
  endtask

  // Executes the instruction at the model pc with plain integer arithmetic.
  task automatic model_step();
    logic [15:0] ins;
    int op, rd, a, b, res, imm, dmod, pmod, f;
    dmod = 1 << DW;
    pmod = 1 << PW;
    ins = imem[mpc];
    op  = int'(ins[15:12]);
    f = int'(ins[11:9]); rd = f % NR;
    f = int'(ins[8:6]);  a  = mreg[f % NR];
    f = int'(ins[5:3]);  b  = mreg[f % NR];
    imm = int'(ins[7:0]);
    res = -1;
    case (op)
      0: begin res = a + b; mc = (res >= dmod); res = res % dmod; end
      1: begin mc = (a < b); res = a - b; if (res < 0) res += dmod; end
      2: begin res = a & b; mc = 0; end
      3: begin res = a | b; mc = 0; end
      4: begin res = a ^ b; mc = 0; end
      default: ;
    endcase
    if (op <= 4) begin
      mz = (res == 0);
      if (rd != 0) mreg[rd] = res;
    end
    if (op == 5 && rd != 0) mreg[rd] = imm % dmod;
    if ((op == 6 && mz) || op == 7) mpc = imm % pmod;
    else                            mpc = (mpc + 1) % pmod;
    if (op == 8) mhalt = 1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; imem_ack = 1'b0; start4 = 1'b0; ack4 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  // Pulses start and runs until the DUT halts, driving the fetch handshake and
  // checking each fetch address, retire timing and post-retire state.
  task automatic run_prog(input int budget, output int ncyc, output int nret);
    int wait_n, need;
    bit pend, acked, acked_prev;
    ncyc = 0; nret = 0; pend = 0; acked_prev = 0;
    fetch_log.delete();
    mhalt = 0;
    imem_ack = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    need = pick_delay(); wait_n = 0;
    while (1) begin
      if (pend) begin
        for (int i = 0; i < NR; i++) begin
          dbg_sel = 3'(i); #1;
          n_tests++;
          if (dbg_data !== DW'(mreg[i])) begin
            n_fail++; $display("FAIL reg_r%0d: got %0d want %0d", i, dbg_data, mreg[i]);
          end
        end
        n_tests++;
        if (flag_z !== mz || flag_c !== mc) begin
          n_fail++; $display("FAIL flags: got z=%b c=%b want z=%b c=%b", flag_z, flag_c, mz, mc);
        end
        n_tests++;
        if (imem_addr !== PW'(mpc) || halted !== mhalt) begin
          n_fail++; $display("FAIL pc_state: got pc=%0d halted=%b want pc=%0d halted=%b",
                             imem_addr, halted, mpc, mhalt);
        end
        pend = 0;
      end
      n_tests++;
      if (retire !== acked_prev) begin
        n_fail++; $display("FAIL retire_timing: got %b want %b", retire, acked_prev);
      end
      if (halted === 1'b1) break;
      if (retire === 1'b1) begin model_step(); nret++; pend = 1; end
      acked = 0;
      if (imem_req === 1'b1) begin
        if (wait_n == 0) fetch_log.push_back(int'(imem_addr));
        n_tests++;
        if (imem_addr !== PW'(mpc)) begin
          n_fail++; $display("FAIL fetch_addr: got %0d want %0d", imem_addr, mpc);
        end
        if (wait_n >= need) begin
          imem_ack = 1'b1; imem_data = imem[imem_addr]; acked = 1;
          wait_n = 0; need = pick_delay();
        end else begin
          imem_ack = 1'b0; wait_n++;
        end
      end else begin
        imem_ack  = 1'($urandom);
        imem_data = 16'($urandom);
      end
      start = inject_start ? 1'($urandom) : 1'b0;
      acked_prev = acked;
      @(posedge clk); #1;
      ncyc++;
      if (ncyc > budget) begin
        n_fail++; $display("FAIL timeout: got %0d cycles want halt within %0d", ncyc, budget);
        break;
      end
    end
    start = 1'b0; imem_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; imem_ack = 1'b0; imem_data = '0; dbg_sel = '0;
    start4 = 1'b0; ack4 = 1'b0; data4 = '0; sel4 = '0;
    #15;
    n_tests++;
    if (halted !== 1'b1 || imem_req !== 1'b0 || retire !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got halted=%b req=%b retire=%b want 1 0 0", halted, imem_req, retire);
    end
    n_tests++;
    if (imem_addr !== '0 || flag_z !== 1'b0 || flag_c !== 1'b0) begin
      n_fail++; $display("FAIL reset_pc_flags: got pc=%0d z=%b c=%b want 0 0 0", imem_addr, flag_z, flag_c);
    end
    for (int i = 0; i < NR; i++) begin
      dbg_sel = 3'(i); #1;
      n_tests++;
      if (dbg_data !== '0) begin
        n_fail++; $display("FAIL reset_r%0d: got %0d want 0", i, dbg_data);
      end
    end
    do_reset();
  endtask

  task automatic test_pc_wrap();
    int exp_a, nf;
    exp_a = 0; nf = 0;
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (req4 === 1'b1) begin
        n_tests++;
        if (addr4 !== 4'(exp_a)) begin
          n_fail++; $display("FAIL pc_wrap: got %0d want %0d", addr4, exp_a);
        end
        exp_a = (exp_a + 1) % 16; nf++;
        ack4 = 1'b1; data4 = 16'h9000;
      end else begin
        ack4 = 1'b0;
      end
      @(posedge clk); #1;
    end
    ack4 = 1'b0;
    n_tests++;
    if (nf < 17) begin
      n_fail++; $display("FAIL pc_wrap_reach: got %0d fetches want >= 17", nf);
    end
    do_reset();
  endtask

  task automatic test_arith();
    int ncyc, nret;
    do_reset();
    foreach (imem[i]) imem[i] = 16'h8000;
    imem[0] = enc_i(5, 1, 200);
    imem[1] = enc_i(5, 2, 100);
    imem[2] = enc_r(0, 3, 1, 2);
    imem[3] = 16'h8000;
    fixed_delay = 0; inject_start = 0;
    run_prog(100, ncyc, nret);
    dbg_sel = 3'd3; #1;
    n_tests++;
    if (dbg_data !== 8'd44 || flag_c !== 1'b1 || flag_z !== 1'b0) begin
      n_fail++; $display("FAIL arith_add: got r3=%0d c=%b z=%b want 44 1 0", dbg_data, flag_c, flag_z);
    end
    n_tests++;
    if (nret != 4 || ncyc != 8) begin
      n_fail++; $display("FAIL arith_timing: got retires=%0d cycles=%0d want 4 8", nret, ncyc);
    end
  endtask

  // Loads a program also used by test_halt_restart (continues from pc 3).
  task automatic test_borrow_zero();
    int ncyc, nret;
    do_reset();
    foreach (imem[i]) imem[i] = 16'h8000;
    imem[0] = enc_i(5, 1, 5);
    imem[1] = enc_r(1, 2, 1, 1);
    imem[2] = 16'h8000;
    imem[3] = enc_r(1, 3, 0, 1);
    imem[4] = 16'h9000;
    imem[5] = 16'h8000;
    imem[6] = enc_r(0, 0, 1, 1);
    imem[7] = 16'h8000;
    fixed_delay = 0; inject_start = 0;
    run_prog(100, ncyc, nret);
    dbg_sel = 3'd2; #1;
    n_tests++;
    if (dbg_data !== 8'd0 || flag_z !== 1'b1 || flag_c !== 1'b0) begin
      n_fail++; $display("FAIL sub_zero: got r2=%0d z=%b c=%b want 0 1 0", dbg_data, flag_z, flag_c);
    end
    n_tests++;
    if (imem_addr !== 8'd3 || halted !== 1'b1) begin
      n_fail++; $display("FAIL halt_pc1: got pc=%0d halted=%b want 3 1", imem_addr, halted);
    end
  endtask

  task automatic test_halt_restart();
    int ncyc, nret;
    fixed_delay = 1; inject_start = 1;
    run_prog(100, ncyc, nret);
    dbg_sel = 3'd3; #1;
    n_tests++;
    if (dbg_data !== 8'd251 || flag_c !== 1'b1 || flag_z !== 1'b0) begin
      n_fail++; $display("FAIL sub_borrow: got r3=%0d c=%b z=%b want 251 1 0", dbg_data, flag_c, flag_z);
    end
    n_tests++;
    if (imem_addr !== 8'd6 || halted !== 1'b1 || nret != 3) begin
      n_fail++; $display("FAIL halt_at5: got pc=%0d halted=%b retires=%0d want 6 1 3", imem_addr, halted, nret);
    end
    repeat (2) begin
      @(posedge clk); #1;
      n_tests++;
      if (halted !== 1'b1 || imem_req !== 1'b0) begin
        n_fail++; $display("FAIL start_in_exec: got halted=%b req=%b want 1 0", halted, imem_req);
      end
    end
    fixed_delay = 0; inject_start = 0;
    run_prog(100, ncyc, nret);
    n_tests++;
    if (fetch_log.size() == 0 || fetch_log[0] != 6) begin
      n_fail++; $display("FAIL restart_addr: got %0d want 6", (fetch_log.size() > 0) ? fetch_log[0] : -1);
    end
    dbg_sel = 3'd0; #1;
    n_tests++;
    if (dbg_data !== 8'd0 || flag_z !== 1'b0 || flag_c !== 1'b0) begin
      n_fail++; $display("FAIL r0_discard: got r0=%0d z=%b c=%b want 0 0 0", dbg_data, flag_z, flag_c);
    end
  endtask

  task automatic test_branch();
    int ncyc, nret;
    int exp_a [7] = '{0, 1, 16, 17, 18, 19, 3};
    do_reset();
    foreach (imem[i]) imem[i] = 16'h8000;
    imem[0]     = enc_r(1, 1, 1, 1);
    imem[1]     = enc_i(6, 0, 8'h10);
    imem[8'h10] = enc_i(5, 1, 1);
    imem[8'h11] = enc_r(3, 2, 1, 1);
    imem[8'h12] = enc_i(6, 0, 8'h40);
    imem[8'h13] = enc_i(7, 0, 8'h03);
    imem[3]     = 16'h8000;
    fixed_delay = 0; inject_start = 0;
    run_prog(100, ncyc, nret);
    n_tests++;
    if (fetch_log.size() != 7) begin
      n_fail++; $display("FAIL branch_len: got %0d fetches want 7", fetch_log.size());
    end else begin
      for (int i = 0; i < 7; i++) begin
        n_tests++;
        if (fetch_log[i] != exp_a[i]) begin
          n_fail++; $display("FAIL branch_seq%0d: got %0d want %0d", i, fetch_log[i], exp_a[i]);
        end
      end
    end
  endtask

  task automatic test_stall();
    int ncyc, nret;
    logic [PW-1:0] pc_idle;
    do_reset();
    foreach (imem[i]) imem[i] = 16'h8000;
    imem[0] = enc_i(5, 1, 3);
    imem[1] = enc_r(0, 2, 1, 1);
    fixed_delay = 3; inject_start = 1;
    run_prog(200, ncyc, nret);
    dbg_sel = 3'd2; #1;
    n_tests++;
    if (ncyc != 15 || nret != 3 || dbg_data !== 8'd6) begin
      n_fail++; $display("FAIL stall: got cycles=%0d retires=%0d r2=%0d want 15 3 6", ncyc, nret, dbg_data);
    end
    pc_idle = imem_addr;
    for (int i = 0; i < 4; i++) begin
      imem_ack = 1'b1; imem_data = enc_i(7, 0, 8'h55);
      @(posedge clk); #1;
      n_tests++;
      if (halted !== 1'b1 || imem_req !== 1'b0 || retire !== 1'b0 || imem_addr !== pc_idle) begin
        n_fail++; $display("FAIL stray_ack: got halted=%b req=%b retire=%b pc=%0d want 1 0 0 %0d",
                           halted, imem_req, retire, imem_addr, pc_idle);
      end
    end
    imem_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    int ncyc, nret, nr;
    bit hit;
    do_reset();
    foreach (imem[i]) imem[i] = 16'h8000;
    imem[0] = 16'h9000;
    fixed_delay = 0; inject_start = 0;
    run_prog(100, ncyc, nret);
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    imem_ack = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (imem_req !== 1'b1 || imem_addr !== 8'd2) begin
      n_fail++; $display("FAIL stall_setup: got req=%b pc=%0d want 1 2", imem_req, imem_addr);
    end
    #3 rst = 1'b1;
    #1;
    n_tests++;
    if (imem_req !== 1'b0 || halted !== 1'b1 || imem_addr !== '0 || retire !== 1'b0) begin
      n_fail++; $display("FAIL rst_fetch: got req=%b halted=%b pc=%0d retire=%b want 0 1 0 0",
                         imem_req, halted, imem_addr, retire);
    end
    @(posedge clk); #1; rst = 1'b0; model_reset();

    imem[0] = enc_i(5, 1, 7);
    imem[1] = enc_i(5, 2, 9);
    imem[2] = enc_r(0, 3, 1, 2);
    imem[3] = 16'h8000;
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    nr = 0; hit = 0;
    for (int cyc = 0; cyc < 20 && !hit; cyc++) begin
      if (retire === 1'b1) nr++;
      if (nr == 3) begin
        hit = 1;
        #2 rst = 1'b1;
        #1;
        dbg_sel = 3'd3; #1;
        n_tests++;
        if (imem_req !== 1'b0 || halted !== 1'b1 || imem_addr !== '0 || retire !== 1'b0 || dbg_data !== '0) begin
          n_fail++; $display("FAIL rst_exec: got req=%b halted=%b pc=%0d retire=%b r3=%0d want 0 1 0 0 0",
                             imem_req, halted, imem_addr, retire, dbg_data);
        end
        @(posedge clk); #1; rst = 1'b0;
        dbg_sel = 3'd3; #1;
        n_tests++;
        if (dbg_data !== '0 || halted !== 1'b1) begin
          n_fail++; $display("FAIL rst_exec_after: got r3=%0d halted=%b want 0 1", dbg_data, halted);
        end
      end else begin
        imem_ack  = imem_req;
        imem_data = imem[imem_addr];
        @(posedge clk); #1;
      end
    end
    imem_ack = 1'b0;
    n_tests++;
    if (!hit) begin
      n_fail++; $display("FAIL rst_exec_reach: got %0d retires want 3", nr);
    end
    model_reset();
  endtask

  task automatic test_random();
    int ncyc, nret, len, r, tgt;
    for (int k = 0; k < 8; k++) begin
      do_reset();
      foreach (imem[i]) imem[i] = 16'h8000;
      len = int'($urandom_range(10, 40));
      for (int a = 0; a < len; a++) begin
        r = int'($urandom_range(0, 9));
        tgt = int'($urandom_range(a + 1, len));
        if (r <= 5)      imem[a] = {4'(r), 12'($urandom)};
        else if (r == 6) imem[a] = enc_i(6, int'($urandom_range(0, 7)), tgt);
        else if (r == 7) imem[a] = enc_i(7, 0, tgt);
        else             imem[a] = {4'($urandom_range(9, 15)), 12'($urandom)};
      end
      fixed_delay = -1; inject_start = 1;
      run_prog(1000, ncyc, nret);
      n_tests++;
      if (nret < 1 || halted !== 1'b1) begin
        n_fail++; $display("FAIL random_done%0d: got retires=%0d halted=%b want >=1 1", k, nret, halted);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pc_wrap();
    test_arith();
    test_borrow_zero();
    test_halt_restart();
    test_branch();
    test_stall();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mini_cpu_mc.md
# mini_cpu_mc

Parametrised multi-cycle successor to the team's single-cycle mini processor. Width, register count and PC width are generic. Instructions come from an external memory over a req/ack handshake. It adds logic ops, zero/carry flags, branches, HALT/start control, a retire strobe and a debug register read port. It sits between the instruction ROM/loader and the system's debug/trace logic.

## Interface
- DATA_W, 8, register/ALU data width (4..32)
- NREGS, 4, register count; power of two, 2..8
- PC_W, 8, program counter and imem address width (4..16)
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- start  in  1  one-cycle pulse; leaves IDLE and begins fetching at current pc
- imem_req  out  1  instruction fetch request
- imem_addr  out  PC_W  fetch address (= pc)
- imem_ack  in  1  fetch data valid this cycle
- imem_data  in  16  instruction word, sampled when imem_req & imem_ack
- halted  out  1  high in IDLE
- retire  out  1  one-cycle pulse per executed instruction
- flag_z  out  1  zero flag
- flag_c  out  1  carry/borrow flag
- dbg_sel  in  3  debug register index (low log2(NREGS) bits used)
- dbg_data  out  DATA_W  combinational read of regfile[dbg_sel]

## Operation
- Instruction fields:
  - opcode = [15:12]; rd = [11:9]; rs1 = [8:6]; rs2 = [5:3]; imm8 = [7:0].
  - Register indices use their low log2(NREGS) bits.
- Register file:
  - R0 always reads 0; writes to R0 are discarded.
  - dbg_data also returns 0 for index 0.
- Opcodes:
  - 0 ADD: rd = rs1 + rs2; C = carry out of bit DATA_W-1.
  - 1 SUB: rd = rs1 - rs2; C = 1 when rs1 < rs2 unsigned (borrow).
  - 2 AND, 3 OR, 4 XOR: rd = rs1 op rs2; C cleared.
  - 5 LDI: rd = imm8, zero-extended or truncated to DATA_W; flags unchanged.
  - 6 BRZ: if Z, pc = imm8 (zero-extended or truncated to PC_W); otherwise pc + 1.
  - 7 JMP: pc = imm8 (zero-extended or truncated to PC_W).
  - 8 HALT: pc = pc + 1, then go to IDLE.
  - 9..15 NOP: pc + 1 only.
- Z is set when the written result is 0. Z is updated by opcodes 0-4 only, including when rd = R0.
- pc arithmetic is modulo 2^PC_W, so 2^PC_W - 1 wraps to 0.
- State machine:
  - IDLE: halted = 1. start → FETCH. start in any other state is ignored.
  - FETCH: imem_req = 1, imem_addr = pc, held stable until imem_ack. On ack, latch imem_data into the instruction register and go to EXEC.
  - EXEC: one cycle. Update regfile/flags/pc, pulse retire. HALT → IDLE; all other opcodes → FETCH.
- Reset values: state IDLE, pc 0, all registers 0, flag_z 0, flag_c 0, imem_req 0, imem_addr 0, halted 1, retire 0.
- Reset mid-fetch or mid-execute:
  - Outputs return to reset values immediately (asynchronous).
  - The in-flight instruction is discarded and registers are not written.

## Timing
- Minimum 2 cycles per instruction: imem_ack in the first FETCH cycle, then EXEC.
- Each cycle of ack delay adds one cycle.
- imem_ack while imem_req = 0 is ignored.
- retire is asserted in the EXEC cycle. Register/flag/pc results are visible on the next rising edge.
- start is sampled in IDLE. imem_req rises in the cycle after start.
- halted falls in the cycle after start. halted rises in the cycle after EXEC of HALT.
- dbg_data is combinational. A write made in EXEC is visible on dbg_data after that edge.

## Test plan
- Arithmetic and flags (DATA_W = 8, ack every fetch):
  - Program LDI R1,200; LDI R2,100; ADD R3,R1,R2; HALT.
  - Expect R3 = 44, C = 1, Z = 0, 4 retire pulses, halted after 8 cycles from start.
- Borrow and zero, plus R0 discard:
  - LDI R1,5; SUB R2,R1,R1 → R2 = 0, Z = 1, C = 0.
  - SUB R3,R0,R1 → R3 = 251, C = 1.
  - ADD R0,R1,R1 → dbg_data(0) = 0, Z = 0.
- Branching:
  - BRZ with Z = 1 → next imem_addr = imm8.
  - BRZ with Z = 0 → pc + 1.
  - JMP 0x03 → imem_addr = 3.
  - PC_W = 4, pc = 15, NOP → imem_addr = 0.
- Handshake stall:
  - imem_ack delayed 3 cycles.
  - imem_req and imem_addr are stable throughout; no retire until the cycle after ack.
  - Stray imem_ack in IDLE has no effect.
- HALT and restart:
  - HALT at address 5 → halted = 1, pc = 6.
  - start in EXEC is ignored.
  - start in IDLE → fetch from address 6.
- Reset mid-operation:
  - Assert rst during FETCH with imem_req high, and again during EXEC of ADD.
  - imem_req drops in the same cycle, destination register stays 0, halted = 1, pc = 0.
